// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - parametrised per-instruction stage/command sequencer
//
// Walks one instruction through the stages selected by stage_mask, lowest
// first. Each stage runs 1+repeat_count iterations, and each iteration ends on
// op_done. The sequencer also tracks the TX command of the current iteration
// and counts reads that have been issued but not yet answered.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   inst_valid          instruction present (held stable until inst_done)
//   skip                instruction not executed (cc false / no-op)
//   stage_mask          bit s set: stage s is used
//   repeat_count        per-stage extra iterations, REPEAT_BITS per stage
//   stage_send_read     bit s set: stage s issues a read command
//   op_done             ALU finished the current iteration
//   tx_command_started  TX accepted tx_command_valid
//   rx_done             reply to the oldest outstanding read received
//   running             an instruction is being sequenced
//   stage, stage_onehot current stage (one-hot is zero when idle)
//   iter, last_iter     iteration within stage, and final-iteration flag
//   command_active      this iteration's command has been started
//   tx_command_valid    request to start a TX command
//   reads_outstanding   reads in flight
//   inst_done           single-cycle retire pulse
module stage_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int REPEAT_BITS = 4,
  parameter int MAX_READS   = 2,
  localparam int SB = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int RB = $clog2(MAX_READS + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              inst_valid,
  input  logic                              skip,
  input  logic [NUM_STAGES-1:0]             stage_mask,
  input  logic [NUM_STAGES*REPEAT_BITS-1:0] repeat_count,
  input  logic [NUM_STAGES-1:0]             stage_send_read,
  input  logic                              op_done,
  input  logic                              tx_command_started,
  input  logic                              rx_done,
  output logic                              running,
  output logic [SB-1:0]                     stage,
  output logic [NUM_STAGES-1:0]             stage_onehot,
  output logic [REPEAT_BITS-1:0]            iter,
  output logic                              last_iter,
  output logic                              command_active,
  output logic                              tx_command_valid,
  output logic [RB-1:0]                     reads_outstanding,
  output logic                              inst_done
);

  localparam logic [RB-1:0] READ_LIMIT = RB'(MAX_READS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SB-1:0]          stage_q, stage_d;
  logic [REPEAT_BITS-1:0] iter_q, iter_d;
  logic                   cmd_q, cmd_d;
  logic [RB-1:0]          reads_q, reads_d;

  logic [REPEAT_BITS-1:0] cur_repeat;
  logic [SB-1:0]          first_stage;
  logic [SB-1:0]          next_stage;
  logic                   next_found;
  logic                   read_issue;
  logic                   read_retire;

  assign cur_repeat = repeat_count[stage_q*REPEAT_BITS +: REPEAT_BITS];

  assign running           = (state_q == RUN);
  assign stage             = stage_q;
  assign stage_onehot      = running ? (NUM_STAGES'(1) << stage_q) : '0;
  assign iter              = iter_q;
  assign last_iter         = running && (iter_q == cur_repeat);
  assign command_active    = cmd_q;
  assign reads_outstanding = reads_q;
  assign tx_command_valid  = running && stage_send_read[stage_q] && !cmd_q
                             && (reads_q < READ_LIMIT);

  // Lowest set mask bit overall, and lowest set bit strictly above the
  // current stage. Scanning downwards lets the lowest match win.
  always_comb begin
    first_stage = '0;
    next_stage  = '0;
    next_found  = 1'b0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (stage_mask[s]) begin
        first_stage = SB'(s);
        if (s > int'(stage_q)) begin
          next_stage = SB'(s);
          next_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    iter_d    = iter_q;
    cmd_d     = cmd_q;
    inst_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_valid) begin
          if (skip || (stage_mask == '0)) begin
            inst_done = 1'b1;
          end else begin
            state_d = RUN;
            stage_d = first_stage;
            iter_d  = '0;
            cmd_d   = 1'b0;
          end
        end
      end
      RUN: begin
        if (!inst_valid) begin
          // Abort: instruction withdrawn, no retire pulse.
          state_d = IDLE;
          stage_d = '0;
          iter_d  = '0;
          cmd_d   = 1'b0;
        end else if (skip) begin
          inst_done = 1'b1;
          state_d   = IDLE;
          stage_d   = '0;
          iter_d    = '0;
          cmd_d     = 1'b0;
        end else if (op_done) begin
          // op_done takes priority over a same-cycle command start.
          cmd_d = 1'b0;
          if (!last_iter) begin
            iter_d = iter_q + 1'b1;
          end else if (next_found) begin
            stage_d = next_stage;
            iter_d  = '0;
          end else begin
            inst_done = 1'b1;
            state_d   = IDLE;
            stage_d   = '0;
            iter_d    = '0;
          end
        end else if (tx_command_started && tx_command_valid) begin
          cmd_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads survive inst_done and abort; they retire whenever replies arrive.
  assign read_issue  = tx_command_started && tx_command_valid;
  assign read_retire = rx_done && (reads_q != '0);

  always_comb begin
    reads_d = reads_q;
    if (read_issue && !read_retire) begin
      reads_d = reads_q + 1'b1;
    end else if (read_retire && !read_issue) begin
      reads_d = reads_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      iter_q  <= '0;
      cmd_q   <= 1'b0;
      reads_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      iter_q  <= iter_d;
      cmd_q   <= cmd_d;
      reads_q <= reads_d;
    end
  end

endmodule
